// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port arbiter in front of a single-port registered program ROM
//
// Purpose: shares one synchronous ROM between port 0 (processor fetch) and
// port 1 (auxiliary table reader). A request accepted in IDLE drives the ROM
// address, the FSM waits out ROM_LATENCY edges, then captures ROM_DATA into
// RDATA and pulses VALID for the winning port.
//
// Configuration macro: ROM_ARB_RR_EN
//   defined   - round-robin on ties (port not granted last wins; port 0 first)
//   undefined - fixed priority, port 0 always wins ties
//
// Ports:
//   CLK, RESETN        clock (rising edge), asynchronous active-low reset
//   REQ0/ADDR0         port 0 request and address
//   GNT0/VALID0        port 0 accept pulse, result-valid pulse
//   REQ1/ADDR1         port 1 request and address
//   GNT1/VALID1        port 1 accept pulse, result-valid pulse
//   RDATA              last captured ROM word, held until next capture
//   BUSY               high whenever the FSM is outside IDLE
//   ROM_ADDR/ROM_DATA  registered address to the ROM, read data from the ROM

module rom_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  output logic                  GNT0,
  output logic                  VALID0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  output logic                  GNT1,
  output logic                  VALID1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // WAIT counts down to zero, so loading LATENCY-1 gives exactly ROM_LATENCY
  // edges between the address update and the capture edge.
  localparam logic [3:0] CNT_INIT = 4'(ROM_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       owner;    // 0 = port 0, 1 = port 1
  logic       any_req;
  logic       win;      // arbitration result, 1 selects port 1

  assign any_req = REQ0 | REQ1;

`ifdef ROM_ARB_RR_EN
  // Last granted port; reset to 1 so the first tie goes to port 0.
  logic last_gnt;

  always_comb begin
    win = ~REQ0;
    if (REQ0 && REQ1) begin
      win = ~last_gnt;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last_gnt <= 1'b1;
    end else if (state == ST_IDLE && any_req) begin
      last_gnt <= win;
    end
  end
`else
  assign win = ~REQ0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (any_req) state_next = ST_WAIT;
      ST_WAIT:    if (cnt == 4'd0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // BUSY comes straight from the state register, so it has no input path.
  assign BUSY = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      VALID0   <= 1'b0;
      VALID1   <= 1'b0;
      RDATA    <= '0;
      ROM_ADDR <= '0;
      cnt      <= 4'd0;
      owner    <= 1'b0;
    end else begin
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      VALID0 <= 1'b0;
      VALID1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            ROM_ADDR <= win ? ADDR1 : ADDR0;
            owner    <= win;
            GNT0     <= ~win;
            GNT1     <= win;
            cnt      <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          RDATA  <= ROM_DATA;
          VALID0 <= ~owner;
          VALID1 <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port synchronous program ROM (8-bit address, 8-bit data, registered read) between two bus requesters.
  - Port 0 is the processor instruction/data fetch.
  - Port 1 is the auxiliary reader (mouse/VGA table lookup).
- Arbitrates, drives the ROM address, waits out the ROM read latency, then returns captured data to the winner with a one-cycle VALID pulse.
- Sits between the requesters and the ROM; the ROM's CLK is shared with this block.

Parameters:
- ADDR_WIDTH, 8, ROM address width; must match the ROM.
- DATA_WIDTH, 8, ROM data width.
- ROM_LATENCY, 1, clock edges from ROM_ADDR change to ROM_DATA valid; legal range 1..15.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- REQ0  input  1  port 0 read request.
- ADDR0  input  ADDR_WIDTH  port 0 address; stable while REQ0 high and not yet granted.
- GNT0  output  1  one-cycle pulse: port 0 request accepted.
- VALID0  output  1  one-cycle pulse: RDATA holds port 0 result.
- REQ1  input  1  port 1 read request.
- ADDR1  input  ADDR_WIDTH  port 1 address.
- GNT1  output  1  one-cycle pulse: port 1 request accepted.
- VALID1  output  1  one-cycle pulse: RDATA holds port 1 result.
- RDATA  output  DATA_WIDTH  returned read data; holds its value until the next capture.
- BUSY  output  1  high when the FSM is not in IDLE.
- ROM_ADDR  output  ADDR_WIDTH  registered address to the ROM.
- ROM_DATA  input  DATA_WIDTH  data from the ROM.

Behaviour:
- Reset (RESETN low, asynchronous):
  - State IDLE; GNT0/1, VALID0/1, BUSY = 0.
  - RDATA = 0, ROM_ADDR = 0, latency counter = 0, owner = 0.
  - Round-robin pointer set so that port 0 wins the first tie.
- Reset asserted mid-transaction: the in-flight read is discarded and no VALID is issued for it.
- Outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE, at an edge where REQ0 or REQ1 is high:
  - Select the winner (fixed priority: port 0 over port 1).
  - ROM_ADDR <= winner's ADDR; owner <= winner; GNTx <= 1 for one cycle.
  - cnt <= ROM_LATENCY-1; go to WAIT.
  - With no request, stay in IDLE; ROM_ADDR holds its value.
- WAIT: each edge, if cnt == 0 go to CAPTURE, else cnt <= cnt-1. REQ inputs are ignored.
- CAPTURE: at the edge, RDATA <= ROM_DATA, VALID(owner) <= 1 for one cycle, go to IDLE.
- Latency and throughput:
  - Request sampled at edge E gives GNT high after E and VALID high after E+ROM_LATENCY+1.
  - With default ROM_LATENCY=1: GNT at E, VALID at E+2.
  - One access per ROM_LATENCY+2 cycles.
- Handshake rules:
  - Requester holds REQ/ADDR until it sees GNT, then may drop REQ.
  - A REQ still high when the FSM re-enters IDLE counts as a new request.
  - The non-winning request stays pending and is served next, since REQ is re-sampled in IDLE.
- Simultaneous events: both REQ high in IDLE resolves by priority; GNT0 and GNT1 are never high together, and neither are VALID0 and VALID1.
- Address changes while not granted are legal; the value sampled at the grant edge is used.
- Address wrap is not applicable; the full 2**ADDR_WIDTH space is passed through unmodified.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer records the last granted port.
  - On a tie, the port not granted last wins; the pointer updates on every grant.
  - After reset, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties; pointer logic is absent.

Test Plan:
- Reset then idle, ROM preloaded with ROM[a]=a^8'hA5 -> all outputs 0, BUSY=0, ROM_ADDR=0 for 10 cycles.
- REQ0=1, ADDR0=8'h10 sampled at edge E -> GNT0 high after E; ROM_ADDR=8'h10; VALID0 high after E+2 for exactly one cycle; RDATA=8'hB5; BUSY high for 2 cycles.
- REQ0 and REQ1 both held high continuously, ADDR0=8'h01, ADDR1=8'h02:
  - Without ROM_ARB_RR_EN -> port 0 granted every time, port 1 starved; RDATA=8'hA4 each VALID0.
  - With ROM_ARB_RR_EN -> grants alternate 0,1,0,1; VALID1 returns RDATA=8'hA7.
- REQ1 asserted alone, then REQ0 asserted one cycle later while in WAIT -> port 1 completes with VALID1 first; port 0 is granted at the next IDLE edge; no overlapping VALIDs.
- RESETN pulsed low during WAIT after GNT0 -> no VALID0 ever issued; outputs 0 immediately (asynchronous); a fresh request after release completes normally.
- ROM_LATENCY=3 with a matching 3-stage ROM model, REQ1 at edge E, ADDR1=8'hFF -> VALID1 after E+4; RDATA=8'h5A.
